// File: rtl/vr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vr_arb_pkg
//  Purpose  : Shared types and helpers for the round-robin valid/ready
//             arbiter (vr_rr_arbiter) and its winner picker (vr_rr_pick).
//  Contents : arb_state_t  - lock FSM state (ARB / LOCK)
//             rr_next()    - round-robin successor, (ptr + 1) mod n
//  Revision : 1.0 - initial release
// ============================================================================
package vr_arb_pkg;

    // Explicit 1-bit encoding so the state register width is fixed.
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Successor of ptr in modulo-n order.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vr_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : vr_rr_pick
//  Purpose  : Combinational round-robin winner search. Returns the first
//             requesting index at or after ptr, wrapping modulo NUM_REQ.
//  Ports    : req [NUM_REQ] in  - request vector
//             ptr [GID_W]   in  - highest-priority index this cycle
//             any           out - at least one request is set
//             w   [GID_W]   out - winning index (0 when any is low)
//  Revision : 1.0 - initial release
// ============================================================================
module vr_rr_pick
    import vr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic               any,
    output logic [GID_W-1:0]   w
);

    int v_idx;

    // Walk NUM_REQ positions starting at ptr; the first hit is kept.
    always_comb begin
        any   = 1'b0;
        w     = '0;
        v_idx = int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[v_idx]) begin
                any = 1'b1;
                w   = GID_W'(v_idx);
            end
            v_idx = rr_next(v_idx, NUM_REQ);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vr_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one valid/ready sink between
//             NUM_REQ valid/ready sources, with a single registered output
//             stage. Feeds the MD5 core message-word input.
//  Options  : VR_ARB_MSG_LOCK_EN - when defined, a winning source keeps the
//             grant for BEATS_PER_MSG accepted beats (one MD5 block).
//  Ports    : clk                          in  - rising-edge clock
//             reset                        in  - synchronous, active low
//             s_data  [NUM_REQ][DATA_WIDTH] in  - source data
//             s_valid [NUM_REQ]            in  - source valid
//             s_ready [NUM_REQ]            out - source ready (one-hot or 0)
//             m_data  [DATA_WIDTH]         out - registered sink data
//             m_valid                      out - registered sink valid
//             m_ready                      in  - sink ready
//             m_gid   [GID_W]              out - source index of m_data
//  Revision : 1.0 - initial release
// ============================================================================
module vr_rr_arbiter
    import vr_arb_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int NUM_REQ       = 4,
    parameter  int BEATS_PER_MSG = 16,
    localparam int GID_W         = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]                 s_valid,
    output logic [NUM_REQ-1:0]                 s_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [GID_W-1:0]                   m_gid
);

    generate
        if (NUM_REQ < 2) begin : g_bad_num_req
            $error("vr_rr_arbiter: NUM_REQ must be at least 2");
        end
        if (BEATS_PER_MSG < 1) begin : g_bad_beats
            $error("vr_rr_arbiter: BEATS_PER_MSG must be at least 1");
        end
    endgenerate

    logic                  w_load;
    logic                  w_any;
    logic [GID_W-1:0]      w_win;
    logic                  w_sel_any;
    logic [GID_W-1:0]      w_sel;
    logic                  w_accept;
    logic [GID_W-1:0]      r_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [GID_W-1:0]      r_gid;

    // Output stage can take a new beat when empty or being drained.
    assign w_load = !r_valid || m_ready;

    vr_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GID_W   (GID_W)
    ) u_pick (
        .req (s_valid),
        .ptr (r_ptr),
        .any (w_any),
        .w   (w_win)
    );

`ifdef VR_ARB_MSG_LOCK_EN
    localparam int                 c_cnt_w    = $clog2(BEATS_PER_MSG + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BEATS_PER_MSG - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [GID_W-1:0]     r_owner;
    logic [GID_W-1:0]     w_owner_nxt;
    logic [GID_W-1:0]     w_ptr_nxt;

    // While locked only the owner can be granted; a missing owner beat
    // leaves the sink idle rather than letting another source in.
    always_comb begin
        w_sel     = w_win;
        w_sel_any = w_any;
        if (r_state == LOCK) begin
            w_sel     = r_owner;
            w_sel_any = s_valid[r_owner];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARB;
            r_cnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ARB: begin
                if (w_accept) begin
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = c_cnt_w'(1);
                    // Single-beat messages finish on the winning beat.
                    if (BEATS_PER_MSG == 1) begin
                        w_ptr_nxt = GID_W'(rr_next(int'(w_win), NUM_REQ));
                    end else begin
                        w_state_nxt = LOCK;
                    end
                end
            end
            LOCK: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        w_ptr_nxt   = GID_W'(rr_next(int'(r_owner), NUM_REQ));
                        w_state_nxt = ARB;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end
`else
    assign w_sel     = w_win;
    assign w_sel_any = w_any;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= GID_W'(rr_next(int'(w_win), NUM_REQ));
        end
    end
`endif

    // Reset gates the grant so no source sees ready while held in reset.
    assign w_accept = reset && w_sel_any && w_load;

    always_comb begin
        s_ready = '0;
        if (w_accept) begin
            s_ready[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_gid   <= '0;
        end else if (w_load) begin
            if (w_accept) begin
                r_data  <= s_data[w_sel];
                r_gid   <= w_sel;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_data  = r_data;
    assign m_valid = r_valid;
    assign m_gid   = r_gid;

endmodule
`default_nettype wire

// File: tb/tb_vr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vr_rr_arbiter
//  Purpose  : Self-checking bench for vr_rr_arbiter. Directed scenarios
//             followed by randomized traffic, all compared against a
//             behavioural model of the arbitration rules.
//  Options  : VR_ARB_MSG_LOCK_EN - enables the message-lock scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vr_rr_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int B  = 16;
    localparam int GW = 2;
`ifdef VR_ARB_MSG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0][DW-1:0]   s_data;
    logic [N-1:0]           s_valid;
    logic [N-1:0]           s_ready;
    logic [DW-1:0]          m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [GW-1:0]          m_gid;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          mptr     = 0;
    int          owner    = -1;
    int          beats    = 0;
    bit          mvalid   = 1'b0;
    logic [DW-1:0] mdata  = '0;
    int          mgid     = 0;
    int          last_acc = -1;

    vr_rr_arbiter #(
        .DATA_WIDTH    (DW),
        .NUM_REQ       (N),
        .BEATS_PER_MSG (B)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_gid   (m_gid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which source should be granted right now, or -1 for none.
    function automatic int exp_grant();
        if (!reset) return -1;
        if (mvalid && !m_ready) return -1;
        if (owner >= 0) return s_valid[owner] ? owner : -1;
        for (int k = 0; k < N; k++) begin
            if (s_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    // One clock: check grant before the edge, advance model, check outputs.
    task automatic cyc();
        int            g;
        logic [N-1:0]  er;
        logic [DW-1:0] d;
        bit            rs;
        bit            mr;
        #3;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("s_ready", s_ready, er);
        d  = (g >= 0) ? s_data[g] : '0;
        rs = reset;
        mr = m_ready;
        @(posedge clk);
        #1;
        last_acc = g;
        if (!rs) begin
            mvalid = 1'b0; mdata = '0; mgid = 0;
            mptr = 0; owner = -1; beats = 0;
        end else if (!mvalid || mr) begin
            if (g >= 0) begin
                mvalid = 1'b1;
                mdata  = d;
                mgid   = g;
                if (LOCK_EN) begin
                    if (owner < 0) begin
                        owner = g;
                        beats = 0;
                    end
                    beats++;
                    if (beats == B) begin
                        mptr  = (g + 1) % N;
                        owner = -1;
                    end
                end else begin
                    mptr = (g + 1) % N;
                end
            end else begin
                mvalid = 1'b0;
            end
        end
        chk("m_valid", m_valid, mvalid);
        chk("m_data", m_data, mdata);
        chk("m_gid", m_gid, mgid);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        m_ready = 1'b1;
        s_valid = '1;
        for (int i = 0; i < N; i++) s_data[i] = DW'(32'hA0 + i);

        // Held in reset with every source requesting.
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("rst_s_ready", s_ready, 0);
            cyc();
            chk("rst_m_valid", m_valid, 0);
        end

        // First beat after release comes from source 0.
        reset = 1'b1;
        cyc();
        chk("first_gid", m_gid, 0);
        chk("first_data", m_data, 32'hA0);
`ifndef VR_ARB_MSG_LOCK_EN
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("rr_data", m_data, 32'hA0 + (k % 4));
        end
`else
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("lock_start_gid", m_gid, 0);
        end
`endif

        // Backpressure after a beat from source 2.
        pulse_reset();
        s_valid   = 4'b0100;
        s_data[2] = 32'h1234;
        cyc();
        chk("bp_first", m_data, 32'h1234);
        s_valid = 4'b1011;
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("bp_s_ready", s_ready, 0);
            cyc();
            chk("bp_data", m_data, 32'h1234);
            chk("bp_gid", m_gid, 2);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) cyc();

`ifdef VR_ARB_MSG_LOCK_EN
        // Two sources: whole message from 1, then whole message from 3.
        pulse_reset();
        s_valid = 4'b1010;
        for (int k = 0; k < 2 * B; k++) begin
            cyc();
            chk("lock_gid", m_gid, (k < B) ? 1 : 3);
        end

        // Owner pauses for two cycles after its fifth beat.
        pulse_reset();
        s_valid = 4'b1111;
        for (int k = 0; k < 5; k++) cyc();
        s_valid = 4'b1110;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("gap_s_ready", s_ready, 0);
            cyc();
            chk("gap_bubble", m_valid, 0);
        end
        s_valid = 4'b1111;
        for (int k = 0; k < B - 5; k++) begin
            cyc();
            chk("gap_gid", {m_valid, m_gid}, {1'b1, 2'd0});
        end
        cyc();
        chk("gap_next_owner", m_gid, 1);

        // Reset mid-message drops the lock held by source 2.
        pulse_reset();
        s_valid = 4'b0100;
        for (int k = 0; k < 7; k++) cyc();
        reset = 1'b0;
        s_valid = 4'b1111;
        cyc();
        reset = 1'b1;
        for (int k = 0; k < B; k++) begin
            cyc();
            chk("rst_lock_gid", m_gid, 0);
        end
        cyc();
        chk("rst_lock_next", m_gid, 1);
`endif

        // Randomized traffic; a pending request is held until accepted.
        pulse_reset();
        for (int c = 0; c < 800; c++) begin
            reset   = ($urandom_range(0, 63) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(s_valid[i] && last_acc != i)) begin
                    s_valid[i] = ($urandom_range(0, 2) != 0);
                    s_data[i]  = $urandom;
                end
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
